// File: rtl/axo_wb_arbiter.sv
// axo_wb_arbiter: round-robin arbiter for the integer register file's single
// write port, plus a pending-write scoreboard that flags RAW/WAW hazards at issue.
module axo_wb_arbiter #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREQ = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   // writeback requesters (0 = ALU, 1 = LSU, 2 = CSR)
   input  logic [NREQ-1:0]        req_valid,
   input  logic [5*NREQ-1:0]      req_rd,
   input  logic [XLEN*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]        req_ready,
   // register-file write port
   output logic                   rf_we,
   output logic [4:0]             rf_rd,
   output logic [XLEN-1:0]        rf_din,
   // issue-side scoreboard interface
   input  logic                   issue_valid,
   input  logic [4:0]             issue_rd,
   input  logic [4:0]             chk_rs1,
   input  logic [4:0]             chk_rs2,
   input  logic [4:0]             chk_rd,
   input  logic                   chk_rs1_en,
   input  logic                   chk_rs2_en,
   input  logic                   chk_rd_en,
   output logic                   hazard,
   input  logic                   flush,
   output logic                   busy
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // pending_q[0] is kept at zero so x0 never reports a hazard
   logic [31:0]   pending_q, pending_d;
   logic [PW-1:0] ptr_q, ptr_d;

   logic          grant_found;
   logic [PW-1:0] grant_idx;

   // Scan requesters starting at the pointer; first valid one wins
   always_comb begin
      int scan;
      scan        = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         scan = (int'(ptr_q) + k) % int'(NREQ);
         for (int j = 0; j < int'(NREQ); j++) begin
            if (!grant_found && (j == scan) && req_valid[j]) begin
               grant_found = 1'b1;
               grant_idx   = PW'(j);
            end
         end
      end
      // nothing is granted while reset is held
      if (rst) begin
         grant_found = 1'b0;
      end
   end

   // One-hot grant and write-port mux; idle port drives zeros
   always_comb begin
      req_ready = '0;
      rf_rd     = '0;
      rf_din    = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_found && (grant_idx == PW'(i))) begin
            req_ready[i] = 1'b1;
            rf_rd        = req_rd[5*i +: 5];
            rf_din       = req_data[XLEN*i +: XLEN];
         end
      end
      rf_we = grant_found;
   end

   // Next pointer and scoreboard: clear on write, set on issue (set wins), flush wipes all
   always_comb begin
      ptr_d     = ptr_q;
      pending_d = pending_q;
      if (grant_found) begin
         ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
         if (rf_rd != 5'd0) begin
            pending_d[rf_rd] = 1'b0;
         end
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         pending_d[issue_rd] = 1'b1;
      end
      if (flush) begin
         pending_d = '0;
      end
      pending_d[0] = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         ptr_q     <= '0;
      end else begin
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
      end
   end

   // Hazard looks only at registered pending, so an in-flight write still stalls
   always_comb begin
      hazard = 1'b0;
      busy   = 1'b0;
      if (!rst) begin
         hazard = (chk_rs1_en && (chk_rs1 != 5'd0) && pending_q[chk_rs1]) ||
                  (chk_rs2_en && (chk_rs2 != 5'd0) && pending_q[chk_rs2]) ||
                  (chk_rd_en  && (chk_rd  != 5'd0) && pending_q[chk_rd]);
         busy   = |pending_q;
      end
   end

endmodule

// File: tb/tb_axo_wb_arbiter.sv
// tb_axo_wb_arbiter: directed vector table plus randomized run against a
// behavioural model of the write-port arbiter and scoreboard.
module tb_axo_wb_arbiter;

   localparam int XLEN = 32;
   localparam int NREQ = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [4:0]           rdv [NREQ];
   logic [XLEN-1:0]      dv  [NREQ];
   logic [5*NREQ-1:0]    req_rd;
   logic [XLEN*NREQ-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 rf_we;
   logic [4:0]           rf_rd;
   logic [XLEN-1:0]      rf_din;
   logic                 issue_valid;
   logic [4:0]           issue_rd, chk_rs1, chk_rs2, chk_rd;
   logic                 chk_rs1_en, chk_rs2_en, chk_rd_en;
   logic                 hazard, flush, busy;

   assign req_rd   = {rdv[2], rdv[1], rdv[0]};
   assign req_data = {dv[2], dv[1], dv[0]};

   axo_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
      .chk_rs1_en(chk_rs1_en), .chk_rs2_en(chk_rs2_en), .chk_rd_en(chk_rd_en),
      .hazard(hazard), .flush(flush), .busy(busy)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [2:0]  v;
      logic [4:0]  rd0, rd1, rd2;
      logic [31:0] d1;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  c1;
      logic        e1;
      logic [4:0]  cd;
      logic        ed;
      logic        fl;
      logic [2:0]  x_rdy;
      logic        x_we;
      logic [4:0]  x_rd;
      logic [31:0] x_din;
      logic        x_haz;
      logic        x_busy;
   } vec_t;

   vec_t tbl [21];

   // behavioural model state
   bit pend_m [32];
   int ptr_m;

   initial begin
      // rst  v     rd0 rd1 rd2 d1            iv ird c1 e1 cd ed fl | rdy    we rd  din           haz busy
      tbl[0]  = '{1, 3'b111, 5, 6, 7, 32'h11,       1, 3,  3, 1, 0, 0, 0, 3'b000, 0, 0,  32'h0,        0, 0};
      tbl[1]  = '{1, 3'b111, 5, 6, 7, 32'h11,       1, 3,  3, 1, 0, 0, 0, 3'b000, 0, 0,  32'h0,        0, 0};
      tbl[2]  = '{0, 3'b111, 5, 6, 7, 32'h11,       0, 0,  0, 0, 0, 0, 0, 3'b001, 1, 5,  32'h10000005, 0, 0};
      tbl[3]  = '{0, 3'b111, 5, 6, 7, 32'h11,       0, 0,  0, 0, 0, 0, 0, 3'b010, 1, 6,  32'h11,       0, 0};
      tbl[4]  = '{0, 3'b111, 5, 6, 7, 32'h11,       0, 0,  0, 0, 0, 0, 0, 3'b100, 1, 7,  32'h20000007, 0, 0};
      tbl[5]  = '{0, 3'b111, 5, 6, 7, 32'h11,       0, 0,  0, 0, 0, 0, 0, 3'b001, 1, 5,  32'h10000005, 0, 0};
      // RAW on x10
      tbl[6]  = '{0, 3'b000, 0, 0, 0, 32'h0,        1, 10, 10, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0,        0, 0};
      tbl[7]  = '{0, 3'b000, 0, 0, 0, 32'h0,        0, 0,  10, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0,        1, 1};
      tbl[8]  = '{0, 3'b010, 0, 10, 0, 32'hDEADBEEF, 0, 0, 10, 1, 0, 0, 0, 3'b010, 1, 10, 32'hDEADBEEF, 1, 1};
      tbl[9]  = '{0, 3'b000, 0, 0, 0, 32'h0,        0, 0,  10, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0,        0, 0};
      // same-cycle set and clear of x4: set wins
      tbl[10] = '{0, 3'b001, 4, 0, 0, 32'h0,        1, 4,  0, 0, 4, 1, 0, 3'b001, 1, 4,  32'h10000004, 0, 0};
      tbl[11] = '{0, 3'b000, 0, 0, 0, 32'h0,        0, 0,  0, 0, 4, 1, 0, 3'b000, 0, 0,  32'h0,        1, 1};
      tbl[12] = '{0, 3'b010, 0, 4, 0, 32'h44,       0, 0,  0, 0, 4, 1, 0, 3'b010, 1, 4,  32'h44,       1, 1};
      // x0 handling
      tbl[13] = '{0, 3'b000, 0, 0, 0, 32'h0,        1, 0,  0, 1, 0, 0, 0, 3'b000, 0, 0,  32'h0,        0, 0};
      tbl[14] = '{0, 3'b100, 0, 0, 0, 32'h0,        0, 0,  0, 1, 0, 0, 0, 3'b100, 1, 0,  32'h20000000, 0, 0};
      tbl[15] = '{0, 3'b000, 0, 0, 0, 32'h0,        0, 0,  0, 1, 0, 0, 0, 3'b000, 0, 0,  32'h0,        0, 0};
      // flush with pending {3,8,9} and a same-cycle issue of x12
      tbl[16] = '{0, 3'b000, 0, 0, 0, 32'h0,        1, 3,  0, 0, 0, 0, 0, 3'b000, 0, 0,  32'h0,        0, 0};
      tbl[17] = '{0, 3'b000, 0, 0, 0, 32'h0,        1, 8,  3, 1, 0, 0, 0, 3'b000, 0, 0,  32'h0,        1, 1};
      tbl[18] = '{0, 3'b000, 0, 0, 0, 32'h0,        1, 9,  8, 1, 0, 0, 0, 3'b000, 0, 0,  32'h0,        1, 1};
      tbl[19] = '{0, 3'b011, 20, 21, 0, 32'h21,     1, 12, 0, 0, 9, 1, 1, 3'b001, 1, 20, 32'h10000014, 1, 1};
      tbl[20] = '{0, 3'b011, 20, 21, 0, 32'h21,     0, 0,  0, 0, 12, 1, 0, 3'b010, 1, 21, 32'h21,      0, 0};

      rst = 1'b1; req_valid = '0; issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
      chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
      chk_rs1_en = 1'b0; chk_rs2_en = 1'b0; chk_rd_en = 1'b0;
      for (int i = 0; i < NREQ; i++) begin rdv[i] = '0; dv[i] = '0; end
      @(posedge clk); #1;

      // directed table
      for (int i = 0; i < 21; i++) begin
         rst = tbl[i].rst; req_valid = tbl[i].v;
         rdv[0] = tbl[i].rd0; rdv[1] = tbl[i].rd1; rdv[2] = tbl[i].rd2;
         dv[0] = 32'h10000000 | 32'(tbl[i].rd0);
         dv[1] = tbl[i].d1;
         dv[2] = 32'h20000000 | 32'(tbl[i].rd2);
         issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
         chk_rs1 = tbl[i].c1; chk_rs1_en = tbl[i].e1;
         chk_rs2 = '0; chk_rs2_en = 1'b0;
         chk_rd = tbl[i].cd; chk_rd_en = tbl[i].ed;
         flush = tbl[i].fl;
         @(negedge clk);
         chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tbl[i].x_rdy));
         chk($sformatf("v%0d rf_we", i),     32'(rf_we),     32'(tbl[i].x_we));
         chk($sformatf("v%0d rf_rd", i),     32'(rf_rd),     32'(tbl[i].x_rd));
         chk($sformatf("v%0d rf_din", i),    rf_din,         tbl[i].x_din);
         chk($sformatf("v%0d hazard", i),    32'(hazard),    32'(tbl[i].x_haz));
         chk($sformatf("v%0d busy", i),      32'(busy),      32'(tbl[i].x_busy));
         @(posedge clk); #1;
      end

      // randomized run against the model, starting from reset
      for (int c = 0; c < 3000; c++) begin
         int g;
         logic [2:0]  e_rdy;
         logic [4:0]  e_rd;
         logic [31:0] e_din;
         logic        e_haz, e_busy;
         rst         = (c == 0) || ($urandom_range(0, 99) == 0);
         req_valid   = 3'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            rdv[i] = 5'($urandom_range(0, 9));
            dv[i]  = $urandom;
         end
         issue_valid = ($urandom_range(0, 2) != 0);
         issue_rd    = 5'($urandom_range(0, 9));
         chk_rs1 = 5'($urandom_range(0, 9)); chk_rs1_en = 1'($urandom);
         chk_rs2 = 5'($urandom_range(0, 9)); chk_rs2_en = 1'($urandom);
         chk_rd  = 5'($urandom_range(0, 9)); chk_rd_en  = 1'($urandom);
         flush   = ($urandom_range(0, 19) == 0);
         @(negedge clk);

         g = -1;
         if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
               int j;
               j = (ptr_m + k) % NREQ;
               if (g < 0 && req_valid[j]) g = j;
            end
         end
         e_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
         e_rd  = (g >= 0) ? rdv[g] : 5'd0;
         e_din = (g >= 0) ? dv[g] : 32'd0;
         e_busy = 1'b0;
         for (int r = 1; r < 32; r++) if (pend_m[r]) e_busy = 1'b1;
         e_haz = (chk_rs1_en && chk_rs1 != 0 && pend_m[chk_rs1]) ||
                 (chk_rs2_en && chk_rs2 != 0 && pend_m[chk_rs2]) ||
                 (chk_rd_en  && chk_rd  != 0 && pend_m[chk_rd]);
         if (rst) begin e_haz = 1'b0; e_busy = 1'b0; end

         chk("rnd req_ready", 32'(req_ready), 32'(e_rdy));
         chk("rnd rf_we",     32'(rf_we),     32'(g >= 0));
         chk("rnd rf_rd",     32'(rf_rd),     32'(e_rd));
         chk("rnd rf_din",    rf_din,         e_din);
         chk("rnd hazard",    32'(hazard),    32'(e_haz));
         chk("rnd busy",      32'(busy),      32'(e_busy));

         if (rst) begin
            for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
            ptr_m = 0;
         end else begin
            if (g >= 0) begin
               ptr_m = (g + 1) % NREQ;
               if (e_rd != 0) pend_m[e_rd] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) pend_m[issue_rd] = 1'b1;
            if (flush) for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
         end
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/axo_wb_arbiter.md
# axo_wb_arbiter

Write-port arbiter and pending-write scoreboard for the Axolotl integer register file. Several writeback sources (ALU, load/store unit, CSR unit) share the register file's single write port. This block grants that port round-robin and drives rd/we/din into the register file. It also tracks which registers have an issued-but-unwritten result and raises a hazard flag, so that issue stalls on RAW/WAW conflicts.

## Interface
Parameters:
- XLEN, 32, register width.
- NREQ, 3, number of writeback requesters; index 0 = ALU, 1 = LSU, 2 = CSR by convention; legal range 2..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  requester i has a result to write.
- req_rd  in  5*NREQ  destination index of requester i, slice [5*i+4:5*i].
- req_data  in  XLEN*NREQ  result of requester i, slice [XLEN*i+XLEN-1:XLEN*i].
- req_ready  out  NREQ  one-hot grant; the transfer completes on the edge where valid&ready.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file write index.
- rf_din  out  XLEN  register-file write data.
- issue_valid  in  1  an instruction with a destination is issuing this cycle.
- issue_rd  in  5  its destination index.
- chk_rs1, chk_rs2, chk_rd  in  5 each  operand/destination indices of the instruction at issue.
- chk_rs1_en, chk_rs2_en, chk_rd_en  in  1 each  which of the chk_* indices are used.
- hazard  out  1  issue must stall.
- flush  in  1  discard all pending marks (pipeline flush/trap).
- busy  out  1  at least one pending bit set.

## Operation
- State: `pending[31:1]` (one bit per register; x0 is never pending) and the round-robin pointer `ptr` (width clog2(NREQ), range 0..NREQ-1).
- Arbitration is combinational and scans requesters ptr, ptr+1, … mod NREQ. The first with req_valid is granted: exactly one req_ready bit high, or none.
- Write port: rf_we = |req_ready; rf_rd/rf_din = granted requester's rd/data. When no grant, rf_rd = 0 and rf_din = 0.
- Pointer update: on a grant to i, ptr ← (i+1) mod NREQ. With no grant, ptr holds.
- Requesters hold req_valid, req_rd and req_data stable until granted. The arbiter does not check this.
- Pending set: issue_valid && issue_rd≠0 sets pending[issue_rd].
- Pending clear: a grant with rd≠0 clears pending[rd].
- Set and clear of the same index in the same cycle: set wins (newer producer outstanding).
- A grant with rd=0 is accepted; the data is discarded by the register file and pending is untouched.
- A grant for a non-pending rd is legal and only writes the register.
- hazard = (chk_rs1_en && chk_rs1≠0 && pending[chk_rs1]) || the same term for rs2 || the same term for rd. The rd term is the WAW check.
- hazard uses registered pending only: a register whose result is being written this cycle still reports hazard. This is deliberately conservative; the operand becomes readable the next cycle.
- flush: pending ← 0 at the edge; it overrides a same-cycle issue set. ptr is unaffected. Grants in the flush cycle still write the register file.
- busy = |pending.

## Timing
- Reset (edge with rst=1): pending ← 0, ptr ← 0.
- While rst is high: req_ready = 0, rf_we = 0, rf_rd = 0, rf_din = 0, hazard = 0, busy = 0. Requests during reset are not granted.
- Reset overrides flush, issue and grants; reset mid-transfer drops the in-flight request without writing.
- Grant-to-write latency is 0: the register file captures rf_din on the same edge the grant handshake completes.
- Throughput: one write per cycle. With all NREQ requesting continuously, each is granted once every NREQ cycles.
- pending/busy/hazard reflect issue, clear and flush from the cycle after the edge.

## Test plan
- Reset state: assert rst with req_valid=3'b111 and issue_valid=1 → req_ready=0, rf_we=0, busy=0. After release, the first grant goes to req 0.
- Round-robin: req_valid=3'b111 held with distinct rd=5,6,7 → grants 0,1,2,0,… each cycle; rf_rd sequence 5,6,7,5.
- Scoreboard RAW: issue rd=10 → next cycle chk_rs1=10 with en=1 gives hazard=1, busy=1. Grant LSU rd=10 data=0xDEADBEEF → rf_we=1 and rf_din=0xDEADBEEF that cycle; hazard=0 the following cycle.
- Simultaneous set/clear: issue rd=4 in the same cycle as a grant with rd=4 → pending[4]=1 afterwards, hazard on chk_rd=4 stays 1.
- x0 handling: issue rd=0 plus chk_rs1=0 → busy=0, hazard=0. Grant rd=0 → rf_we=1, pending unchanged.
- Flush: pending {3,8,9} set, flush=1 together with issue rd=12 → all pending=0 next cycle, busy=0, ptr unchanged (next grant order continues).
